// File: rtl/command_sequencer.sv
// Command sequencer: polls the thread control register, fetches up to COMMAND_COUNT
// three-word commands, hands them to an executor and writes back status.
// Optional build macro COMMAND_SEQUENCER_OPCODE_CHECK_EN rejects opcodes above MAX_OPCODE.
module command_sequencer #(
    parameter int         BYTES_PER_WORD    = 4,
    parameter int         COMMAND_COUNT     = 4,
    parameter int         BYTES_PER_COMMAND = 12,
    parameter logic [7:0] MAX_OPCODE        = 8'h0F,
    localparam int        ADDR_BITS         = $clog2(12 + BYTES_PER_COMMAND * COMMAND_COUNT),
    localparam int        IDX_BITS          = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1
) (
    input  logic                 gpu_clk,
    input  logic                 gpu_reset_n,
    output logic [ADDR_BITS-1:0] reg_address,
    input  logic [31:0]          reg_rd_data,
    output logic [31:0]          reg_wr_data,
    output logic [3:0]           reg_wr_en,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [95:0]          cmd_data,
    output logic [IDX_BITS-1:0]  cmd_index,
    output logic                 busy
);

    // Handshake: a command transfers on every rising edge where cmd_valid && cmd_ready;
    // while cmd_valid is high and cmd_ready low, cmd_data and cmd_index do not change.

    typedef enum logic [3:0] {
        IDLE, POLL, SET_BUSY, FETCH0, FETCH1, FETCH2, LATCH, DISPATCH, FINISH, CLEAR
    } state_t;

`ifdef COMMAND_SEQUENCER_OPCODE_CHECK_EN
    localparam bit OPCODE_CHECK = 1'b1;
`else
    localparam bit OPCODE_CHECK = 1'b0;
`endif

    localparam logic [ADDR_BITS-1:0] ADDR_STATUS  = ADDR_BITS'(4);
    localparam logic [ADDR_BITS-1:0] ADDR_CONTROL = ADDR_BITS'(8);
    localparam logic [IDX_BITS-1:0]  K_LAST       = IDX_BITS'(COMMAND_COUNT - 1);

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   k_q, k_d;
    logic [3:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic [31:0]           w0_q, w0_d, w1_q, w1_d;
    logic [95:0]           cmd_data_d;
    logic [ADDR_BITS-1:0]  addr_d;
    logic [31:0]           wr_data_d;
    logic [3:0]            wr_en_d;

    function automatic logic [ADDR_BITS-1:0] cmd_addr(input logic [IDX_BITS-1:0] idx,
                                                      input int word);
        int a;
        a = 12 + BYTES_PER_COMMAND * int'(idx) + BYTES_PER_WORD * word;
        return ADDR_BITS'(a);
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        count_d    = count_q;
        err_d      = err_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        cmd_data_d = cmd_data;
        case (state_q)
            // IDLE waits until the control address is actually on the bus, so the
            // first POLL after reset never samples data read from another register.
            IDLE:     if (reg_address == ADDR_CONTROL) state_d = POLL;
            POLL:     if (reg_rd_data[0]) state_d = SET_BUSY;
            SET_BUSY: begin
                state_d = FETCH0;
                k_d     = '0;
                count_d = '0;
                err_d   = 1'b0;
            end
            FETCH0:   state_d = FETCH1;
            FETCH1:   begin
                w0_d    = reg_rd_data;
                state_d = FETCH2;
            end
            FETCH2:   begin
                w1_d    = reg_rd_data;
                state_d = LATCH;
            end
            LATCH: begin
                if (w0_q[7:0] == 8'h00) begin
                    state_d = FINISH;
                end else if (OPCODE_CHECK && (w0_q[7:0] > MAX_OPCODE)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cmd_data_d = {reg_rd_data, w1_q, w0_q};
                    state_d    = DISPATCH;
                end
            end
            DISPATCH: begin
                if (cmd_ready) begin
                    count_d = count_q + 4'd1;
                    if (k_q == K_LAST) begin
                        state_d = FINISH;
                    end else begin
                        k_d     = k_q + IDX_BITS'(1);
                        state_d = FETCH0;
                    end
                end
            end
            FINISH:   state_d = CLEAR;
            CLEAR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state cycle.
    always_comb begin
        addr_d    = reg_address;
        wr_en_d   = 4'b0000;
        wr_data_d = 32'h0;
        case (state_d)
            IDLE, POLL: addr_d = ADDR_CONTROL;
            SET_BUSY: begin
                addr_d    = ADDR_STATUS;
                wr_en_d   = 4'b0001;
                wr_data_d = 32'h1;
            end
            FETCH0:   addr_d = cmd_addr(k_d, 0);
            FETCH1:   addr_d = cmd_addr(k_d, 1);
            FETCH2:   addr_d = cmd_addr(k_d, 2);
            FINISH: begin
                addr_d    = ADDR_STATUS;
                wr_en_d   = 4'b0001;
                wr_data_d = {24'h0, count_d, 1'b0, err_d, ~err_d, 1'b0};
            end
            CLEAR: begin
                addr_d    = ADDR_CONTROL;
                wr_en_d   = 4'b0001;
                wr_data_d = 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            w0_q        <= '0;
            w1_q        <= '0;
            cmd_data    <= '0;
            reg_address <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= '0;
            cmd_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            count_q     <= count_d;
            err_q       <= err_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            cmd_data    <= cmd_data_d;
            reg_address <= addr_d;
            reg_wr_data <= wr_data_d;
            reg_wr_en   <= wr_en_d;
            cmd_valid   <= (state_d == DISPATCH);
            busy        <= !(state_d inside {IDLE, POLL});
        end
    end

    assign cmd_index = k_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: register-file model, transfer/write monitor,
// expected queues checked after each sequence.
module tb_command_sequencer;

    localparam int ADDR_BITS = 6;

    logic                 gpu_clk = 1'b0;
    logic                 gpu_reset_n;
    logic [ADDR_BITS-1:0] reg_address;
    logic [31:0]          reg_rd_data = 32'h0;
    logic [31:0]          reg_wr_data;
    logic [3:0]           reg_wr_en;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [95:0]          cmd_data;
    logic [1:0]           cmd_index;
    logic                 busy;

    command_sequencer dut (
        .gpu_clk     (gpu_clk),
        .gpu_reset_n (gpu_reset_n),
        .reg_address (reg_address),
        .reg_rd_data (reg_rd_data),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_index   (cmd_index),
        .busy        (busy)
    );

    // clock / reset
    always #5 gpu_clk = ~gpu_clk;

    // register file model: one-cycle read latency, byte-0 writes from the DUT
    logic [31:0] mem [0:15];
    logic        host_we = 1'b0;
    logic [3:0]  host_idx = 4'd0;
    logic [31:0] host_data = 32'h0;

    always @(posedge gpu_clk) begin
        reg_rd_data <= mem[reg_address[5:2]];
        if (host_we) mem[host_idx] <= host_data;
        else if (reg_wr_en[0]) mem[reg_address[5:2]][7:0] <= reg_wr_data[7:0];
    end

    // monitor
    logic [41:0] wr_log_q[$];
    logic [97:0] xfer_q[$];
    logic [41:0] exp_wr_q[$];
    logic [97:0] exp_q[$];

    always @(negedge gpu_clk) begin
        if (gpu_reset_n) begin
            if (cmd_valid && cmd_ready) xfer_q.push_back({cmd_index, cmd_data});
            if (reg_wr_en != 4'b0000) wr_log_q.push_back({reg_wr_en, reg_address, reg_wr_data});
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] wr_ent(input logic [5:0] a, input logic [31:0] d);
        return {4'b0001, a, d};
    endfunction

    task automatic check_writes(input string tag);
        check_val({tag, "_nwr"}, 128'(wr_log_q.size()), 128'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < wr_log_q.size(); i++)
            check_val($sformatf("%s_wr%0d", tag, i), 128'(wr_log_q[i]), 128'(exp_wr_q[i]));
    endtask

    task automatic check_xfers(input string tag);
        check_val({tag, "_nxfer"}, 128'(xfer_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < xfer_q.size(); i++)
            check_val($sformatf("%s_xfer%0d", tag, i), 128'(xfer_q[i]), 128'(exp_q[i]));
    endtask

    task automatic clear_logs();
        wr_log_q.delete();
        xfer_q.delete();
        exp_wr_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gpu_clk);
            #1;
        end
    endtask

    task automatic host_write(input int idx, input logic [31:0] d);
        host_idx  = 4'(idx);
        host_data = d;
        host_we   = 1'b1;
        tick(1);
        host_we   = 1'b0;
    endtask

    task automatic load_cmd(input int k, input logic [95:0] d);
        host_write(3 + 3 * k, d[31:0]);
        host_write(4 + 3 * k, d[63:32]);
        host_write(5 + 3 * k, d[95:64]);
    endtask

    task automatic wait_busy_fall(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick(1);
            n++;
        end
        check_val({tag, "_busy_fall"}, 128'(busy), 128'(0));
        tick(3);
    endtask

    task automatic run_seq(input string tag);
        int n;
        host_write(2, 32'h1);
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        check_val({tag, "_busy_rise"}, 128'(busy), 128'(1));
        wait_busy_fall(tag);
    endtask

    logic [95:0] cmd_tbl [4] = '{
        96'h2222_0000_1111_0000_C0DE_0001,
        96'h2222_0001_1111_0001_C0DE_0002,
        96'h2222_0002_1111_0002_C0DE_0003,
        96'h2222_0003_1111_0003_C0DE_0004
    };
    localparam logic [95:0] CMD_OP5    = 96'h2222_0005_1111_0005_C0DE_0005;
    localparam logic [95:0] CMD_OP0    = 96'h0000_0000_0000_0000_C0DE_0000;
    localparam logic [95:0] CMD_OP7    = 96'h3333_3333_4444_4444_5555_0007;
    localparam logic [95:0] CMD_OP20   = 96'h7777_0000_6666_0000_C0DE_0020;

    initial begin
        int n;
        int bad_wr, bad_valid, bad_addr, bad_busy, bad_hold;

        // reset state
        gpu_reset_n = 1'b0;
        cmd_ready   = 1'b1;
        tick(2);
        check_val("rst_addr",    128'(reg_address), 128'(0));
        check_val("rst_wdata",   128'(reg_wr_data), 128'(0));
        check_val("rst_wen",     128'(reg_wr_en),   128'(0));
        check_val("rst_valid",   128'(cmd_valid),   128'(0));
        check_val("rst_data",    128'(cmd_data),    128'(0));
        check_val("rst_index",   128'(cmd_index),   128'(0));
        check_val("rst_busy",    128'(busy),        128'(0));
        for (int i = 0; i < 16; i++) host_write(i, 32'h0);
        host_write(0, 32'h0000_0007);
        gpu_reset_n = 1'b1;
        tick(1);
        check_val("rel_addr", 128'(reg_address), 128'(8));
        tick(3);

        // control=0: nothing happens
        bad_wr = 0; bad_valid = 0; bad_addr = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (reg_wr_en != 4'b0) bad_wr++;
            if (cmd_valid) bad_valid++;
            if (reg_address != 6'd8) bad_addr++;
            if (busy) bad_busy++;
        end
        check_val("idle_wen",   128'(bad_wr),    128'(0));
        check_val("idle_valid", 128'(bad_valid), 128'(0));
        check_val("idle_addr",  128'(bad_addr),  128'(0));
        check_val("idle_busy",  128'(bad_busy),  128'(0));

        // four commands, all dispatched
        for (int k = 0; k < 4; k++) load_cmd(k, cmd_tbl[k]);
        clear_logs();
        run_seq("full");
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), cmd_tbl[k]});
        exp_wr_q.push_back(wr_ent(6'd4, 32'h1));
        exp_wr_q.push_back(wr_ent(6'd4, 32'h42));
        exp_wr_q.push_back(wr_ent(6'd8, 32'h0));
        check_xfers("full");
        check_writes("full");
        check_val("full_status",  128'(mem[1]), 128'(32'h42));
        check_val("full_control", 128'(mem[2]), 128'(32'h0));

        // opcode 0 in slot 1 ends the sequence
        load_cmd(0, CMD_OP5);
        load_cmd(1, CMD_OP0);
        clear_logs();
        run_seq("op0");
        exp_q.push_back({2'd0, CMD_OP5});
        exp_wr_q.push_back(wr_ent(6'd4, 32'h1));
        exp_wr_q.push_back(wr_ent(6'd4, 32'h12));
        exp_wr_q.push_back(wr_ent(6'd8, 32'h0));
        check_xfers("op0");
        check_writes("op0");

        // back-pressure: executor stalls for 20 cycles
        load_cmd(0, CMD_OP7);
        clear_logs();
        cmd_ready = 1'b0;
        host_write(2, 32'h1);
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        check_val("stall_busy_rise", 128'(busy), 128'(1));
        n = 0;
        while (!cmd_valid && n < 20) begin
            tick(1);
            n++;
        end
        check_val("stall_latency", 128'(n), 128'(5));
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cmd_valid || cmd_data !== CMD_OP7 || cmd_index !== 2'd0) bad_hold++;
            tick(1);
        end
        check_val("stall_hold", 128'(bad_hold), 128'(0));
        check_val("stall_noxfer", 128'(xfer_q.size()), 128'(0));
        cmd_ready = 1'b1;
        wait_busy_fall("stall");
        exp_q.push_back({2'd0, CMD_OP7});
        exp_wr_q.push_back(wr_ent(6'd4, 32'h1));
        exp_wr_q.push_back(wr_ent(6'd4, 32'h12));
        exp_wr_q.push_back(wr_ent(6'd8, 32'h0));
        check_xfers("stall");
        check_writes("stall");

        // reset during FETCH1 of command 2 (address 40)
        for (int k = 0; k < 4; k++) load_cmd(k, cmd_tbl[k]);
        clear_logs();
        host_write(2, 32'h1);
        n = 0;
        while (reg_address != 6'd40 && n < 200) begin
            tick(1);
            n++;
        end
        check_val("abort_reach", 128'(reg_address), 128'(40));
        #2;
        gpu_reset_n = 1'b0;
        #1;
        check_val("abort_addr",  128'(reg_address), 128'(0));
        check_val("abort_wdata", 128'(reg_wr_data), 128'(0));
        check_val("abort_wen",   128'(reg_wr_en),   128'(0));
        check_val("abort_valid", 128'(cmd_valid),   128'(0));
        check_val("abort_data",  128'(cmd_data),    128'(0));
        check_val("abort_index", 128'(cmd_index),   128'(0));
        check_val("abort_busy",  128'(busy),        128'(0));
        host_write(2, 32'h0);
        tick(2);
        gpu_reset_n = 1'b1;
        tick(6);
        for (int k = 0; k < 2; k++) exp_q.push_back({2'(k), cmd_tbl[k]});
        exp_wr_q.push_back(wr_ent(6'd4, 32'h1));
        check_xfers("abort");
        check_writes("abort");
        check_val("abort_status", 128'(mem[1]),      128'(32'h1));
        check_val("abort_poll",   128'(reg_address), 128'(8));
        check_val("abort_idle",   128'(busy),        128'(0));

        // out-of-range opcode in slot 0
        load_cmd(0, CMD_OP20);
        load_cmd(1, CMD_OP0);
        clear_logs();
        run_seq("badop");
        exp_wr_q.push_back(wr_ent(6'd4, 32'h1));
`ifdef COMMAND_SEQUENCER_OPCODE_CHECK_EN
        exp_wr_q.push_back(wr_ent(6'd4, 32'h04));
`else
        exp_q.push_back({2'd0, CMD_OP20});
        exp_wr_q.push_back(wr_ent(6'd4, 32'h12));
`endif
        exp_wr_q.push_back(wr_ent(6'd8, 32'h0));
        check_xfers("badop");
        check_writes("badop");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 SHALL have parameters: BYTES_PER_WORD, default 4, bytes per register word; COMMAND_COUNT, default 4, command slots per thread (range 1..15); BYTES_PER_COMMAND, default 12, bytes per command (3 words); MAX_OPCODE, default 8'h0F, highest legal opcode.
REQ-002 SHALL have ports (ADDR_BITS = clog2(12+BYTES_PER_COMMAND*COMMAND_COUNT)):
- gpu_clk  in  1  sole clock, rising edge
- gpu_reset_n  in  1  asynchronous active-low reset
- reg_address  out  ADDR_BITS  byte address into own thread register block
- reg_rd_data  in  32  read data, valid 1 cycle after reg_address
- reg_wr_data  out  32  write data
- reg_wr_en  out  4  byte write enables
- cmd_valid  out  1  command presented
- cmd_ready  in  1  executor accepts command
- cmd_data  out  96  {word2, word1, word0} of current command
- cmd_index  out  clog2(COMMAND_COUNT)  slot number of cmd_data
- busy  out  1  sequence in progress
REQ-003 SHALL use one clock, gpu_clk; reset SHALL be asynchronous and active-low, gpu_reset_n.

Function
REQ-004 Register map SHALL be: 0 thread_id, 4 status, 8 control, 12+12*k command k word0..word2.
REQ-005 Status byte 0 SHALL be {count[3:0], 1'b0, error, done, busy}; control bit0 = start.
REQ-006 States SHALL be IDLE, POLL, SET_BUSY, FETCH0, FETCH1, FETCH2, LATCH, DISPATCH, FINISH, CLEAR.
REQ-007 IDLE: drive reg_address=8, go POLL next cycle; POLL: if reg_rd_data[0]=1 go SET_BUSY, else stay POLL with address held at 8.
REQ-008 SET_BUSY: one-cycle write reg_address=4, reg_wr_data=32'h1, reg_wr_en=4'b0001; busy=1 from this cycle to end of CLEAR; count cleared to 0.
REQ-009 FETCH0..FETCH2: issue addresses 12+12*k, +4, +8 on consecutive cycles; each returned word captured the following cycle; LATCH captures word2; total 4 cycles from FETCH0 to cmd_data valid.
REQ-010 After LATCH, if word0[7:0]==0 go FINISH without dispatch; else enter DISPATCH with cmd_valid=1, cmd_index=k.
REQ-011 DISPATCH: cmd_data/cmd_index SHALL stay stable while cmd_valid=1 and cmd_ready=0; transfer on cycle cmd_valid&cmd_ready; count increments; if k==COMMAND_COUNT-1 go FINISH else k+1, FETCH0.
REQ-012 FINISH: one-cycle write address 4, data {24'h0, count, 4'b0010} (or error bit set), reg_wr_en=4'b0001.
REQ-013 CLEAR: one-cycle write address 8, data 0, reg_wr_en=4'b0001; then IDLE. A start bit written by software during a sequence SHALL be lost.
REQ-014 reg_wr_en SHALL be 0 in every state other than SET_BUSY, FINISH, CLEAR; cmd_valid SHALL be 1 only in DISPATCH.

Reset
REQ-015 On gpu_reset_n=0, immediately: state=IDLE, k=0, count=0, reg_address=0, reg_wr_data=0, reg_wr_en=0, cmd_valid=0, cmd_data=0, cmd_index=0, busy=0.
REQ-016 Reset mid-sequence SHALL abort with no FINISH/CLEAR write; status register contents are left unchanged by this block.
REQ-017 After reset release, first POLL SHALL occur on the second rising edge.

Configuration
REQ-018 Macro COMMAND_SEQUENCER_OPCODE_CHECK_EN: when defined, LATCH with word0[7:0] > MAX_OPCODE SHALL skip dispatch, go FINISH and write status bit2 error=1 (count excludes faulty command); when undefined, any non-zero opcode is dispatched and error bit is always 0.

Verification
REQ-019 Control=1, commands 0..3 opcodes 1,2,3,4, cmd_ready=1 -> 4 transfers, cmd_index 0..3, then status write 32'h42, control write 0, busy falls after CLEAR.
REQ-020 Command 1 opcode 0 -> one transfer (index 0), status write 32'h12.
REQ-021 cmd_ready=0 for 20 cycles during DISPATCH -> cmd_valid held 1, cmd_data unchanged, single transfer on release.
REQ-022 gpu_reset_n pulsed low during FETCH1 of command 2 -> outputs zero asynchronously, no write to address 4 or 8, returns to POLL.
REQ-023 With COMMAND_SEQUENCER_OPCODE_CHECK_EN, command 0 opcode 8'h20 -> no transfer, status write 32'h04; without macro -> transfer occurs.
REQ-024 Control=0 for 100 cycles -> reg_wr_en stays 0, cmd_valid stays 0, reg_address stays 8.
